// File: rtl/mem_pkg.sv
// mem_pkg: shared size encodings, FSM states and stall-request values for mem_ctrl
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    // Encoding 3 is treated as a word access
    function automatic logic [2:0] size_bytes(input logic [1:0] s);
        return s == SZ_BYTE ? 3'd1 : s == SZ_HALF ? 3'd2 : 3'd4;
    endfunction

endpackage

// File: rtl/load_ext.sv
// load_ext: size and sign extension of assembled load data
// Ports: data (assembled little-endian bytes), size (SZ_*), sign_ext (1 = signed),
//        q (extended result)
module load_ext
    import mem_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] q
);

    assign q = size == SZ_BYTE ? {{24{sign_ext & data[7]}}, data[7:0]} :
               size == SZ_HALF ? {{16{sign_ext & data[15]}}, data[15:0]} :
               data;

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial controller serving IF fetches and MEM loads/stores on one 8-bit RAM port
// Ports: clk/rst; IF request (if_req, if_addr -> if_data, if_done); MEM request
//        (mem_req, mem_we, mem_addr, mem_wdata, mem_size, mem_signed -> mem_rdata, mem_done);
//        stall requests to the pipeline; RAM port (ram_addr, ram_we, ram_dout, ram_din).
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_data,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic [1:0]        mem_size,
    input  logic              mem_signed,
    output logic [31:0]       mem_rdata,
    output logic              mem_done,
    output logic              stallreq_from_if,
    output logic              stallreq_from_mem,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din
);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] base;
    logic [2:0]        cnt, n;
    logic [1:0]        size, lane;
    logic              sgn, src_if, accept, fin;
    logic [31:0]       wdata, lanes, merged, ext;
    logic              unused_hi;

    assign unused_hi = ^{if_addr[31:ADDR_W], mem_addr[31:ADDR_W]};

    // Byte cnt-1 arrives on ram_din this cycle; cnt==4 wraps to lane 3
    assign lane = cnt[1:0] - 2'd1;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // No accept in a done cycle: the requester still holds req until it sees done
    always_comb begin
        accept   = state == IDLE && !mem_done && !if_done && (mem_req || if_req);
        fin      = state == READ ? cnt == n : state == WRITE ? cnt == n - 3'd1 : 1'b0;
        state_nx = accept ? (mem_req && mem_we ? WRITE : READ) : fin ? IDLE : state;
        merged   = lanes;
        merged[{lane, 3'b000} +: 8] = ram_din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base      <= '0;
            cnt       <= '0;
            n         <= '0;
            size      <= '0;
            sgn       <= 1'b0;
            src_if    <= 1'b0;
            wdata     <= '0;
            lanes     <= '0;
            if_data   <= '0;
            mem_rdata <= '0;
            if_done   <= 1'b0;
            mem_done  <= 1'b0;
        end else begin
            if_done  <= 1'b0;
            mem_done <= 1'b0;
            if (accept) begin
                src_if <= !mem_req;
                base   <= mem_req ? mem_addr[ADDR_W-1:0] : if_addr[ADDR_W-1:0];
                size   <= mem_req ? mem_size : SZ_WORD;
                n      <= size_bytes(mem_req ? mem_size : SZ_WORD);
                sgn    <= mem_req & mem_signed;
                wdata  <= mem_wdata;
                lanes  <= '0;
                cnt    <= '0;
            end else if (state != IDLE) begin
                cnt <= cnt + 3'd1;
                if (state == READ && cnt != 3'd0) lanes <= merged;
                if (fin) begin
                    if (state == WRITE) begin
                        mem_done <= 1'b1;
                    end else if (src_if) begin
                        if_data <= merged;
                        if_done <= 1'b1;
                    end else begin
                        mem_rdata <= ext;
                        mem_done  <= 1'b1;
                    end
                end
            end
        end
    end

    load_ext u_ext (
        .data     (merged),
        .size     (size),
        .sign_ext (sgn),
        .q        (ext)
    );

    // Byte k of the transaction sits at base+k; the adder wraps modulo 2^ADDR_W
    assign ram_addr          = base + ADDR_W'(cnt);
    assign ram_dout          = wdata[{cnt[1:0], 3'b000} +: 8];
    assign ram_we            = state == WRITE && !rst;
    assign stallreq_from_if  = if_req && !if_done ? Stop : NoStop;
    assign stallreq_from_mem = mem_req && !mem_done ? Stop : NoStop;

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Byte-serial memory controller between the pipeline and a single 8-bit synchronous RAM port. It serves instruction-fetch reads from IF and load/store accesses from MEM, one transaction at a time. While a requester's transaction is outstanding, it drives that requester's stall request. The pipeline stall controller consumes `stallreq_from_if` and `stallreq_from_mem` and freezes the pipeline accordingly.

## Interface
- `ADDR_W`, 17, RAM address width; CPU addresses are truncated to the low `ADDR_W` bits.
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset, synchronous, active-high.
- `if_req` in 1: IF read request, held until `if_done`.
- `if_addr` in 32: fetch address.
- `if_data` out 32: fetched word; valid in the `if_done` cycle and held afterwards.
- `if_done` out 1: one-cycle completion pulse.
- `mem_req` in 1: MEM request, held until `mem_done`.
- `mem_we` in 1: 1 = store, 0 = load.
- `mem_addr` in 32: load/store address.
- `mem_wdata` in 32: store data, low bytes used.
- `mem_size` in 2: 0 = byte, 1 = half, 2 = word; 3 is treated as word.
- `mem_signed` in 1: sign-extend loads.
- `mem_rdata` out 32: extended load data; valid in the `mem_done` cycle and held afterwards.
- `mem_done` out 1: one-cycle completion pulse.
- `stallreq_from_if` out 1: `if_req & ~if_done`.
- `stallreq_from_mem` out 1: `mem_req & ~mem_done`.
- `ram_addr` out ADDR_W: RAM byte address.
- `ram_we` out 1: RAM write enable.
- `ram_dout` out 8: RAM write data.
- `ram_din` in 8: RAM read data, one cycle after address.

## Operation
- FSM states: IDLE, READ, WRITE.
- Transitions from IDLE:
  - With `mem_req` high: latch addr, size, signed and wdata; go to WRITE if `mem_we`, else READ. MEM always wins over IF.
  - Else with `if_req` high: latch `if_addr` and go to READ with size word.
- Byte count N is 1, 2 or 4 per `mem_size`.
- Byte k (k = 0..N-1) uses address `(addr + k) mod 2^ADDR_W`, little-endian order, so wrap-around is allowed. Misaligned accesses are legal.
- READ:
  - Drive byte addresses in successive cycles.
  - Capture `ram_din` one cycle later into byte lane k.
  - After the last capture, extend the result: byte by bit 7, half by bit 15, zero-extend when `mem_signed` = 0.
  - Load the result into `if_data` or `mem_rdata`, pulse the matching done, return to IDLE.
- WRITE:
  - `ram_we` high for N cycles, `ram_dout` = wdata byte k.
  - Pulse `mem_done` in the cycle after the last byte, then return to IDLE.
- A request losing arbitration waits in IDLE priority order. Its stall request stays high the whole time.
- Reset values: state IDLE, `if_data` = `mem_rdata` = 0, both dones 0, `ram_addr` 0, `ram_we` 0.
- `ram_we` is gated by `rst` combinationally so it is 0 in any cycle where `rst` is high.
- Reset mid-transaction aborts the transaction: no done pulse, partial writes remain in RAM.

## Timing
Cycle 0 is the cycle in which the request is accepted in IDLE.
- Read of N bytes:
  - Byte addresses are driven in cycles 1..N.
  - The done pulse and data appear in cycle N+2.
  - A word read therefore completes in cycle 6.
- Write of N bytes: `ram_we` is high in cycles 1..N; done is pulsed in cycle N+1.
- The stall request is high from cycle 0 through the cycle before done, and low in the done cycle.
- After a done, the FSM is in IDLE and can accept a new request in the next cycle, which becomes cycle 0 of that request.
- Requesters must keep req, address and data stable until done; changes are ignored after acceptance.

## Structure
- Shared package (`mem_pkg`) holds:
  - The size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`.
  - The FSM state encodings.
  - The `Stop`/`NoStop` stall-request values used by the stall controller.
- One natural sub-module: `load_ext`, a combinational size and sign extender from the 32-bit assembled data to `mem_rdata`.
- Byte counter, lane assembly register and FSM stay in `mem_ctrl`.

## Test plan
- LW at 0x100, RAM bytes 11,22,33,44 → `ram_addr` 0x100..0x103 in cycles 1–4, `mem_rdata` = 0x44332211 with `mem_done` in cycle 6, `stallreq_from_mem` high in cycles 0–5.
- LB signed at a byte holding 0x80 → 0xFFFFFF80 in cycle 3; LBU at the same byte → 0x00000080; LH signed of bytes 34,F2 → 0xFFFFF234.
- SW 0xDEADBEEF at 0x200 → `ram_we` high in cycles 1–4 with (0x200, EF), (0x201, BE), (0x202, AD), (0x203, DE), `mem_done` in cycle 5.
- `if_req` and `mem_req` rise together (LW) → MEM served first with `mem_done` in cycle 6. IF is accepted in cycle 7 and completes with `if_done` in cycle 13. `stallreq_from_if` stays high in cycles 0–12.
- LW at 0x1FFFF with `ADDR_W` = 17 → addresses 0x1FFFF, 0x00000, 0x00001, 0x00002.
- `rst` asserted in cycle 2 of an SW → `ram_we` = 0 in cycle 2, no `mem_done`, state IDLE and all outputs at reset values from cycle 3.
